// File: rtl/mem_access_stage.sv
// mem_access_stage: M pipeline register, data-memory access FSM with timeout, and W register.
// Aligns store data into byte lanes, extends loads, and stalls upstream while an access waits.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_E,
  input  logic [31:0] ALU_result_E,
  input  logic [31:0] write_data_E,
  input  logic [4:0]  rd_E,
  input  logic        reg_write_E,
  input  logic        mem_read_E,
  input  logic        mem_write_E,
  input  logic [2:0]  funct3_E,
  input  logic        flush_M,
  output logic [31:0] ALU_result_M,
  output logic [4:0]  rd_M,
  output logic        reg_write_M,
  output logic        stall_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] WB_data_W,
  output logic [4:0]  rd_W,
  output logic        reg_write_W,
  output logic        misalign_fault,
  output logic        bus_error
);
  // state  | meaning
  // IDLE   | no access outstanding; an aligned access in M requests the bus this cycle
  // WAIT   | access held on the bus awaiting dmem_ready; counter runs down to timeout
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  // First IDLE cycle counts toward the budget, so WAIT gets TIMEOUT_CYCLES-1 cycles.
  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYCLES - 2);

  state_t      state, state_nx;
  logic [7:0]  tmo_cnt, tmo_cnt_nx;

  logic [31:0] write_data_m;
  logic        mem_read_m, mem_write_m;
  logic [2:0]  funct3_m;

  logic [1:0]  a_lo;
  logic        access_m, size_bad, misalign_m, aligned_m, timeout_m;
  logic [3:0]  be_raw;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_result_M <= '0;
      write_data_m <= '0;
      rd_M         <= '0;
      reg_write_M  <= 1'b0;
      mem_read_m   <= 1'b0;
      mem_write_m  <= 1'b0;
      funct3_m     <= '0;
    end else if (!stall_M) begin
      if (valid_E && !flush_M) begin
        ALU_result_M <= ALU_result_E;
        write_data_m <= write_data_E;
        rd_M         <= rd_E;
        reg_write_M  <= reg_write_E;
        mem_read_m   <= mem_read_E;
        mem_write_m  <= mem_write_E;
        funct3_m     <= funct3_E;
      end else begin
        ALU_result_M <= '0;
        write_data_m <= '0;
        rd_M         <= '0;
        reg_write_M  <= 1'b0;
        mem_read_m   <= 1'b0;
        mem_write_m  <= 1'b0;
        funct3_m     <= '0;
      end
    end
  end

  assign a_lo     = ALU_result_M[1:0];
  assign access_m = mem_read_m | mem_write_m;

  always_comb begin
    size_bad = 1'b0;
    case (funct3_m[1:0])
      2'b00:   size_bad = 1'b0;
      2'b01:   size_bad = a_lo[0];
      default: size_bad = (a_lo != 2'b00);
    endcase
  end

  assign misalign_m = access_m & size_bad;
  assign aligned_m  = access_m & ~size_bad;
  assign timeout_m  = (state == S_WAIT) && (tmo_cnt == 8'd0) && !dmem_ready;
  assign stall_M    = aligned_m & ~dmem_ready & ~timeout_m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      tmo_cnt <= 8'd0;
    end else begin
      state   <= state_nx;
      tmo_cnt <= tmo_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    tmo_cnt_nx = tmo_cnt;
    case (state)
      S_IDLE: begin
        if (aligned_m && !dmem_ready) begin
          state_nx   = S_WAIT;
          tmo_cnt_nx = TMO_LOAD;
        end
      end
      S_WAIT: begin
        if (!aligned_m || dmem_ready || tmo_cnt == 8'd0) begin
          state_nx = S_IDLE;
        end else begin
          tmo_cnt_nx = tmo_cnt - 8'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    be_raw = 4'b1111;
    case (funct3_m[1:0])
      2'b00:   be_raw = 4'b0001 << a_lo;
      2'b01:   be_raw = 4'b0011 << a_lo;
      default: be_raw = 4'b1111;
    endcase
    dmem_wdata = write_data_m;
    case (funct3_m[1:0])
      2'b00:   dmem_wdata = {4{write_data_m[7:0]}};
      2'b01:   dmem_wdata = {2{write_data_m[15:0]}};
      default: dmem_wdata = write_data_m;
    endcase
    dmem_req  = aligned_m;
    dmem_we   = aligned_m & mem_write_m;
    dmem_be   = aligned_m ? be_raw : 4'b0000;
    dmem_addr = {ALU_result_M[31:2], 2'b00};
  end

  always_comb begin
    lane_b = dmem_rdata[7:0];
    case (a_lo)
      2'b00: lane_b = dmem_rdata[7:0];
      2'b01: lane_b = dmem_rdata[15:8];
      2'b10: lane_b = dmem_rdata[23:16];
      2'b11: lane_b = dmem_rdata[31:24];
      default: lane_b = dmem_rdata[7:0];
    endcase
    lane_h = a_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = dmem_rdata;
    case (funct3_m[1:0])
      2'b00:   load_data = {{24{lane_b[7] & ~funct3_m[2]}}, lane_b};
      2'b01:   load_data = {{16{lane_h[15] & ~funct3_m[2]}}, lane_h};
      default: load_data = dmem_rdata;
    endcase
  end

  // A stalled cycle hands W a bubble; faulted ops reach W without a register write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_data_W      <= '0;
      rd_W           <= '0;
      reg_write_W    <= 1'b0;
      misalign_fault <= 1'b0;
      bus_error      <= 1'b0;
    end else if (stall_M) begin
      reg_write_W    <= 1'b0;
      misalign_fault <= 1'b0;
      bus_error      <= 1'b0;
    end else begin
      rd_W           <= rd_M;
      WB_data_W      <= (mem_read_m && aligned_m) ? load_data : ALU_result_M;
      reg_write_W    <= reg_write_M & ~misalign_m & ~timeout_m;
      misalign_fault <= misalign_m;
      bus_error      <= timeout_m;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed test-plan ops plus random ops, checked per cycle
// against a transaction-level model (cycles spent in M, lane rules, extension arithmetic).
module tb_mem_access_stage;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_E;
  logic [31:0] ALU_result_E;
  logic [31:0] write_data_E;
  logic [4:0]  rd_E;
  logic        reg_write_E, mem_read_E, mem_write_E;
  logic [2:0]  funct3_E;
  logic        flush_M;
  logic [31:0] ALU_result_M;
  logic [4:0]  rd_M;
  logic        reg_write_M, stall_M;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [31:0] WB_data_W;
  logic [4:0]  rd_W;
  logic        reg_write_W, misalign_fault, bus_error;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        valid, flush, rw, mr, mw;
    logic [2:0]  f3;
    logic [31:0] alu, wd, rdata;
    logic [4:0]  rd;
    int          lat;
  } op_t;

  op_t ops[$];

  mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .valid_E(valid_E), .ALU_result_E(ALU_result_E),
    .write_data_E(write_data_E), .rd_E(rd_E), .reg_write_E(reg_write_E),
    .mem_read_E(mem_read_E), .mem_write_E(mem_write_E), .funct3_E(funct3_E),
    .flush_M(flush_M), .ALU_result_M(ALU_result_M), .rd_M(rd_M), .reg_write_M(reg_write_M),
    .stall_M(stall_M), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .WB_data_W(WB_data_W), .rd_W(rd_W),
    .reg_write_W(reg_write_W), .misalign_fault(misalign_fault), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_live(input op_t o);
    return o.valid && !o.flush;
  endfunction

  function automatic bit is_acc(input op_t o);
    return is_live(o) && (o.mr || o.mw);
  endfunction

  function automatic bit is_aligned(input op_t o);
    return (int'(o.alu[1:0]) % size_of(o.f3)) == 0;
  endfunction

  function automatic logic [3:0] exp_be(input op_t o);
    logic [3:0] mask;
    mask = 4'((1 << size_of(o.f3)) - 1);
    return mask << o.alu[1:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input op_t o);
    if (size_of(o.f3) == 1) return {24'h0, o.wd[7:0]} * 32'h0101_0101;
    if (size_of(o.f3) == 2) return {16'h0, o.wd[15:0]} * 32'h0001_0001;
    return o.wd;
  endfunction

  function automatic logic [31:0] exp_load(input op_t o);
    logic [31:0] v;
    int unsigned sh;
    sh = 8 * int'(o.alu[1:0]);
    v = o.rdata >> sh;
    if (size_of(o.f3) == 1) begin
      v = v & 32'hFF;
      if (!o.f3[2] && v >= 32'd128) v = v - 32'd256;
    end else if (size_of(o.f3) == 2) begin
      v = v & 32'hFFFF;
      if (!o.f3[2] && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = o.rdata;
    end
    return v;
  endfunction

  function automatic op_t mk_mem(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [4:0] rd, input int lat,
                                 input logic [31:0] rdata);
    op_t o;
    o.valid = 1'b1; o.flush = 1'b0; o.rw = ld; o.mr = ld; o.mw = !ld;
    o.f3 = f3; o.alu = addr; o.wd = wd; o.rd = rd; o.lat = lat; o.rdata = rdata;
    return o;
  endfunction

  function automatic op_t mk_alu(input logic [31:0] res, input logic [4:0] rd);
    op_t o;
    o.valid = 1'b1; o.flush = 1'b0; o.rw = 1'b1; o.mr = 1'b0; o.mw = 1'b0;
    o.f3 = 3'($urandom); o.alu = res; o.wd = $urandom; o.rd = rd; o.lat = 0; o.rdata = '0;
    return o;
  endfunction

  function automatic op_t mk_idle();
    op_t o;
    o = mk_mem(1'b1, 3'($urandom), $urandom, $urandom, 5'($urandom), 0, $urandom);
    o.valid = 1'b0;
    return o;
  endfunction

  task automatic drive_e(input op_t o);
    valid_E = o.valid; flush_M = o.flush; ALU_result_E = o.alu; write_data_E = o.wd;
    rd_E = o.rd; reg_write_E = o.rw; mem_read_E = o.mr; mem_write_E = o.mw; funct3_E = o.f3;
  endtask

  // Plays ops[] through the stage; entered ~1ns after a rising edge with M empty.
  task automatic run_ops();
    int  m, w, guard, limit;
    op_t cur, nxt;
    bit  al, rdy, tmo, leave, exp_rw;
    m = -1; w = 0; guard = 0; limit = 40 * ops.size() + 40;
    while (m < ops.size() && guard < limit) begin
      guard++;
      if (m >= 0) cur = ops[m]; else cur = mk_idle();
      if (m + 1 < ops.size()) nxt = ops[m + 1]; else nxt = mk_idle();
      al  = is_acc(cur) && is_aligned(cur);
      rdy = al ? (w == cur.lat) : 1'($urandom_range(0, 1));
      tmo = al && !rdy && (w == TMO - 1);
      drive_e(nxt);
      if (al && !rdy && !tmo && !nxt.flush) flush_M = 1'($urandom_range(0, 1));
      dmem_ready = rdy;
      dmem_rdata = (al && rdy) ? cur.rdata : $urandom;
      @(negedge clk);
      chk("dmem_req", dmem_req, al);
      chk("stall_M", stall_M, al && !rdy && !tmo);
      if (al) begin
        chk("dmem_addr", dmem_addr, cur.alu & 32'hFFFF_FFFC);
        chk("dmem_be", dmem_be, exp_be(cur));
        chk("dmem_we", dmem_we, cur.mw);
        if (cur.mw) chk("dmem_wdata", dmem_wdata, exp_wdata(cur));
      end
      leave = !(al && !rdy && !tmo);
      @(posedge clk);
      #1;
      if (leave) begin
        exp_rw = is_live(cur) && cur.rw && !(is_acc(cur) && !al) && !tmo;
        chk("reg_write_W", reg_write_W, exp_rw);
        if (exp_rw) begin
          chk("WB_data_W", WB_data_W, cur.mr ? exp_load(cur) : cur.alu);
          chk("rd_W", rd_W, cur.rd);
        end
        chk("misalign_fault", misalign_fault, is_acc(cur) && !al);
        chk("bus_error", bus_error, tmo);
        m++;
        w = 0;
      end else begin
        chk("reg_write_W_stall", reg_write_W, 1'b0);
        chk("bus_error_stall", bus_error, 1'b0);
        w++;
      end
      if (m >= 0 && m < ops.size()) begin
        cur = ops[m];
        chk("reg_write_M", reg_write_M, is_live(cur) && cur.rw);
        if (is_live(cur)) begin
          chk("ALU_result_M", ALU_result_M, cur.alu);
          chk("rd_M", rd_M, cur.rd);
        end
      end
    end
    chk("drain", m, ops.size());
    ops.delete();
  endtask

  initial begin
    op_t         o;
    int          k, lat;
    logic [31:0] addr;

    rst_n = 1'b0;
    drive_e(mk_idle());
    valid_E = 1'b0; flush_M = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
    #12;
    chk("rst_ALU_result_M", ALU_result_M, 32'h0);
    chk("rst_rd_M", rd_M, 5'd0);
    chk("rst_reg_write_M", reg_write_M, 1'b0);
    chk("rst_stall_M", stall_M, 1'b0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_dmem_we", dmem_we, 1'b0);
    chk("rst_dmem_be", dmem_be, 4'h0);
    chk("rst_WB_data_W", WB_data_W, 32'h0);
    chk("rst_rd_W", rd_W, 5'd0);
    chk("rst_reg_write_W", reg_write_W, 1'b0);
    chk("rst_misalign_fault", misalign_fault, 1'b0);
    chk("rst_bus_error", bus_error, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    ops.push_back(mk_mem(1'b1, 3'b010, 32'h0000_0100, 32'h0, 5'd5, 0, 32'hDEAD_BEEF));
    ops.push_back(mk_mem(1'b1, 3'b000, 32'h0000_0103, 32'h0, 5'd6, 0, 32'h8012_3456));
    ops.push_back(mk_mem(1'b1, 3'b100, 32'h0000_0103, 32'h0, 5'd7, 0, 32'h8012_3456));
    ops.push_back(mk_mem(1'b1, 3'b001, 32'h0000_0102, 32'h0, 5'd8, 0, 32'h8001_1234));
    ops.push_back(mk_mem(1'b0, 3'b000, 32'h0000_0201, 32'h0000_00A5, 5'd0, 3, 32'h0));
    ops.push_back(mk_alu(32'h0000_1234, 5'd9));
    ops.push_back(mk_mem(1'b0, 3'b010, 32'h0000_0102, 32'h1111_2222, 5'd0, 0, 32'h0));
    ops.push_back(mk_alu(32'h0000_0055, 5'd10));
    ops.push_back(mk_mem(1'b1, 3'b010, 32'h0000_0300, 32'h0, 5'd11, 99, 32'h0));
    ops.push_back(mk_alu(32'hCAFE_0001, 5'd12));
    ops.push_back(mk_mem(1'b1, 3'b010, 32'h0000_0304, 32'h0, 5'd13, TMO - 1, 32'h1357_9BDF));
    ops.push_back(mk_mem(1'b1, 3'b101, 32'h0000_0102, 32'h0, 5'd14, 1, 32'h8001_1234));
    ops.push_back(mk_mem(1'b1, 3'b011, 32'h0000_0104, 32'h0, 5'd15, 1, 32'hA5A5_0F0F));
    ops.push_back(mk_mem(1'b1, 3'b111, 32'h0000_0106, 32'h0, 5'd16, 0, 32'h0));
    ops.push_back(mk_mem(1'b0, 3'b001, 32'h0000_0412, 32'hBEEF_C0DE, 5'd0, 2, 32'h0));
    run_ops();

    for (int i = 0; i < 50; i++) begin
      k    = int'($urandom_range(0, 9));
      lat  = ($urandom_range(0, 7) == 0) ? 99 : int'($urandom_range(0, 4));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      if (k < 3) o = mk_alu($urandom, 5'($urandom));
      else if (k < 6) o = mk_mem(1'b1, 3'($urandom), addr, $urandom, 5'($urandom), lat, $urandom);
      else if (k < 9) o = mk_mem(1'b0, 3'($urandom), addr, $urandom, 5'($urandom), lat, $urandom);
      else begin
        o = mk_mem(1'b1, 3'b010, addr & 32'hFFFF_FFFC, $urandom, 5'($urandom), lat, $urandom);
        if ($urandom_range(0, 1) == 1) o.valid = 1'b0; else o.flush = 1'b1;
      end
      ops.push_back(o);
    end
    run_ops();

    drive_e(mk_mem(1'b1, 3'b010, 32'h0000_0400, 32'h0, 5'd9, 99, 32'h0));
    flush_M = 1'b0;
    dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    drive_e(mk_idle());
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("wait_dmem_req", dmem_req, 1'b1);
    chk("wait_stall_M", stall_M, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_dmem_req", dmem_req, 1'b0);
    chk("arst_stall_M", stall_M, 1'b0);
    chk("arst_dmem_be", dmem_be, 4'h0);
    chk("arst_dmem_we", dmem_we, 1'b0);
    chk("arst_ALU_result_M", ALU_result_M, 32'h0);
    chk("arst_rd_M", rd_M, 5'd0);
    chk("arst_reg_write_M", reg_write_M, 1'b0);
    chk("arst_WB_data_W", WB_data_W, 32'h0);
    chk("arst_reg_write_W", reg_write_W, 1'b0);
    chk("arst_bus_error", bus_error, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ops.push_back(mk_mem(1'b1, 3'b010, 32'h0000_0500, 32'h0, 5'd17, 0, 32'h0BAD_F00D));
    ops.push_back(mk_alu(32'h7777_0000, 5'd18));
    ops.push_back(mk_mem(1'b1, 3'b010, 32'h0000_0504, 32'h0, 5'd19, 99, 32'h0));
    run_ops();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline stage directly downstream of the execute stage. It registers the execute-stage outputs (ALU result, forwarded store data, destination register, memory controls), performs load/store accesses on a req/ready data-memory bus with byte-lane alignment and load sign/zero extension, and produces the writeback-stage register. It stalls the upstream pipeline while a memory access is outstanding. It also supplies the memory-stage ALU result used by execute-stage forwarding.

## Interface
- TIMEOUT_CYCLES, 16: maximum wait cycles for dmem_ready before the access is aborted with a bus error; legal range 2..255.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_E  in  1  execute stage holds a valid instruction
- ALU_result_E  in  32  effective address, or result for non-memory ops
- write_data_E  in  32  forwarded store data (rs2)
- rd_E  in  5  destination register
- reg_write_E, mem_read_E, mem_write_E  in  1 each  control bits
- funct3_E  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- flush_M  in  1  squash the instruction entering M (branch redirect)
- ALU_result_M  out  32  M-stage ALU result (forwarding source)
- rd_M, reg_write_M  out  5, 1  for the hazard unit
- stall_M  out  1  freeze PC/IF/ID/EX registers this cycle
- dmem_req, dmem_we  out  1 each  bus request and write strobe
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  store data replicated into byte lanes
- dmem_be  out  4  byte enables
- dmem_ready  in  1  access completes this cycle
- dmem_rdata  in  32  read word, valid when dmem_ready=1
- WB_data_W  out  32  load data (extended) or ALU result
- rd_W, reg_write_W  out  5, 1  writeback controls
- misalign_fault, bus_error  out  1 each  one-cycle fault pulses

## Operation
- M register: captures E inputs on every clock with stall_M=0. flush_M=1 or valid_E=0 captures a bubble (all controls 0). While stall_M=1 the M register holds.
- Access type: mem_read_M or mem_write_M. Non-access instructions pass to W in one cycle; WB_data_W = ALU_result_M.
- Alignment check, combinational on M: H with addr[0]=1, or W with addr[1:0]≠0, is misaligned. A misaligned op asserts no dmem_req, pulses misalign_fault in the cycle it leaves M, and moves to W with reg_write_W=0.
- Store lanes: B: be=4'b0001<<addr[1:0], wdata = {4{byte}}. H: be=4'b0011<<addr[1:0], wdata = {2{half}}. W: be=4'b1111. Loads drive be from the same rule; dmem_we=0.
- Load extraction: select the byte/half of dmem_rdata by addr[1:0], then sign-extend (B, H) or zero-extend (BU, HU). funct3 values 011/110/111 are treated as W.
- FSM states:
  - IDLE: M holds no aligned access. An aligned access present in M gives dmem_req=1 combinationally. dmem_ready=1 completes it in the same cycle. Otherwise go to WAIT and clear the counter.
  - WAIT: dmem_req=1; addr/be/wdata/we are held stable. dmem_ready=1 completes and returns to IDLE. When the counter reaches TIMEOUT_CYCLES-1 without ready: pulse bus_error, drop the op (reg_write_W=0), return to IDLE.
- stall_M = aligned access in M AND dmem_ready=0 AND not timing out this cycle.
- flush_M while stall_M=1 is ignored; flush applies only to the E→M capture.

## Timing
- Reset: all M/W registers, ALU_result_M, WB_data_W, rd_*, reg_write_*, dmem_req, dmem_we, dmem_be, misalign_fault, bus_error = 0. FSM goes to IDLE and the counter to 0.
- Reset asserted mid-access: dmem_req drops immediately (asynchronous). The access is lost and is never retried.
- Latency E→W: 2 edges for non-memory ops and zero-wait accesses. Each wait cycle adds 1 edge.
- dmem_ready sampled while dmem_req=0 is ignored.
- Back-to-back accesses: a new access may issue in the cycle after completion, with no idle gap.
- Fault pulses are exactly 1 cycle wide, aligned with the faulting op's W capture edge.

## Test plan
- LW at 0x100, ready same cycle, rdata=0xDEADBEEF -> req for 1 cycle, stall_M=0, next edge WB_data_W=0xDEADBEEF, reg_write_W=1.
- LB at 0x103 with rdata=0x80xxxxxx, then LBU same address -> 0xFFFFFF80, then 0x00000080. LH at 0x102 with rdata=0x8001xxxx -> 0xFFFF8001.
- SB 0xA5 at 0x201, ready after 3 wait cycles -> dmem_be=4'b0010, wdata=0xA5A5A5A5, we=1; stall_M high 3 cycles with addr stable; the upstream E instruction enters M after completion.
- SW at 0x102 -> no dmem_req, misalign_fault pulses once, reg_write_W=0. A following ADD passes normally.
- LW with ready never asserted (TIMEOUT_CYCLES=16) -> stall_M high 15 cycles, bus_error pulses on the 16th cycle, reg_write_W=0, then the pipeline resumes.
- Access waiting in WAIT, rst_n pulsed low -> dmem_req=0 immediately, all outputs 0; after release the FSM is IDLE and the next LW completes normally.
